// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - byte-serial AES-128 key schedule streaming round keys 0..10
module aes_key_expand (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] key_in,
   input  logic       key_valid,
   output logic       key_ready,
   output logic [7:0] rk_out,
   output logic       rk_valid,
   input  logic       rk_ready,
   output logic [3:0] rk_round,
   output logic       rk_last,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, LOAD, EMIT, EXPAND} state_t;

   // Byte 0x00 of the S-box sits in the top byte of the table.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[{~b, 3'b000} +: 8];
   endfunction

   // Indexed by the round being left, so it yields Rcon of the round being built.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd0:    return 8'h01;
         4'd1:    return 8'h02;
         4'd2:    return 8'h04;
         4'd3:    return 8'h08;
         4'd4:    return 8'h10;
         4'd5:    return 8'h20;
         4'd6:    return 8'h40;
         4'd7:    return 8'h80;
         4'd8:    return 8'h1b;
         4'd9:    return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   state_t        state_q, state_d;
   logic [127:0]  key_q, key_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [3:0]    rnd_q, rnd_d;
   logic          done_q, done_d;

   logic [31:0]   w0, w1, w2, w3, t, n0, n1, n2, n3;

   assign w0 = key_q[127:96];
   assign w1 = key_q[95:64];
   assign w2 = key_q[63:32];
   assign w3 = key_q[31:0];
   assign t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
               ^ {rcon(rnd_q), 24'h0};
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         key_q   <= '0;
         cnt_q   <= '0;
         rnd_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         cnt_q   <= cnt_d;
         rnd_q   <= rnd_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      cnt_d   = cnt_q;
      rnd_d   = rnd_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               key_d   = '0;
               cnt_d   = '0;
               rnd_d   = '0;
            end
         end
         LOAD: begin
            if (key_valid) begin
               key_d = {key_q[119:0], key_in};
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15) state_d = EMIT;
            end
         end
         EMIT: begin
            if (rk_ready) begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  if (rnd_q == 4'd10) begin
                     // Final key is wiped so nothing survives for reuse.
                     state_d = IDLE;
                     done_d  = 1'b1;
                     key_d   = '0;
                     rnd_d   = '0;
                  end else begin
                     state_d = EXPAND;
                  end
               end
            end
         end
         EXPAND: begin
            key_d   = {n0, n1, n2, n3};
            rnd_d   = rnd_q + 4'd1;
            cnt_d   = '0;
            state_d = EMIT;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      key_ready = 1'b0;
      rk_valid  = 1'b0;
      rk_out    = 8'h00;
      rk_last   = 1'b0;
      rk_round  = rnd_q;
      busy      = (state_q != IDLE);
      done      = done_q;
      case (state_q)
         LOAD: key_ready = 1'b1;
         EMIT: begin
            rk_valid = 1'b1;
            rk_out   = key_q[{~cnt_q, 3'b000} +: 8];
            rk_last  = (cnt_q == 4'd15);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - scoreboard bench for aes_key_expand
module tb_aes_key_expand;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] key_in = 8'h00;
   logic       key_valid = 1'b0;
   logic       key_ready;
   logic [7:0] rk_out;
   logic       rk_valid;
   logic       rk_ready = 1'b1;
   logic [3:0] rk_round;
   logic       rk_last;
   logic       busy;
   logic       done;

   aes_key_expand dut (
      .clock(clock), .reset(reset), .start(start), .key_in(key_in),
      .key_valid(key_valid), .key_ready(key_ready), .rk_out(rk_out),
      .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_round(rk_round),
      .rk_last(rk_last), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   localparam logic [127:0] A1_RK [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };
   localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;

   typedef struct {
      logic [7:0] data;
      logic       care;
      logic [3:0] round;
      logic       last;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         obs = 0;
   int         last_cnt = 0;
   int         rk_gap = 0;
   logic       stall_prev = 1'b0;
   logic [11:0] held;

   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock) begin
      #1;
      rk_ready = ($urandom_range(99) >= rk_gap);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   // Returns {care, round key}; which: 0 = FIPS A.1, 1 = 00..0f, 2 = all-zero.
   function automatic logic [128:0] exp_rk(input int which, input int r);
      case (which)
         0: return {1'b1, A1_RK[r]};
         1: begin
            if (r == 0)  return {1'b1, KEY2};
            if (r == 10) return {1'b1, 128'h13111d7fe3944a17f307a78b4d2b30c5};
            return {1'b0, 128'h0};
         end
         default: begin
            if (r == 0) return {1'b1, 128'h0};
            if (r == 1) return {1'b1, 128'h62636363626363636263636362636363};
            if (r == 2) return {1'b1, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
            return {1'b0, 128'h0};
         end
      endcase
   endfunction

   task automatic push_run(input int which, input int nbytes);
      exp_t       e;
      logic [128:0] v;
      for (int i = 0; i < nbytes; i++) begin
         v       = exp_rk(which, i / 16);
         e.data  = v[127 - 8 * (i % 16) -: 8];
         e.care  = v[128];
         e.round = 4'(i / 16);
         e.last  = ((i % 16) == 15);
         sb_q.push_back(e);
      end
   endtask

   always @(negedge clock) begin
      if (stall_prev && rk_valid)
         check("stall_hold", 32'({rk_round, rk_out}), 32'(held));
      stall_prev = rk_valid && !rk_ready;
      held       = {rk_round, rk_out};
      if (!rk_valid) check("rk_out_zero_when_invalid", 32'({rk_out, rk_last}), 32'h0);
      if (!busy)     check("rk_round_zero_when_idle", 32'(rk_round), 32'h0);
      if (rk_valid && rk_ready) begin
         obs++;
         if (rk_last) last_cnt++;
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte actual=%0h required=none at cycle %0d", rk_out, cyc);
         end else begin
            mon_e = sb_q.pop_front();
            if (mon_e.care) check("rk_out", 32'(rk_out), 32'(mon_e.data));
            check("rk_round_last", 32'({rk_round, rk_last}), 32'({mon_e.round, mon_e.last}));
         end
      end
   end

   task automatic start_pulse(output int t);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      t = cyc;
   endtask

   task automatic drive_key(input logic [127:0] k, input int gap, input int nbytes);
      int  i = 0;
      int  n = 0;
      logic hs;
      while (i < nbytes && n < 400) begin
         key_valid = ($urandom_range(99) >= gap);
         key_in    = k[127 - 8 * i -: 8];
         @(negedge clock);
         check("key_ready_in_load", 32'({busy, key_ready, rk_valid}), 32'h6);
         hs = key_valid && key_ready;
         @(posedge clock);
         #1;
         if (hs) i++;
         n++;
      end
      key_valid = 1'b0;
   endtask

   task automatic wait_done(input int t, input bit check_span);
      int n = 0;
      while (n < 3000) begin
         @(negedge clock);
         if (done) break;
         n++;
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=no_done required=done from start cycle %0d", t);
      end else begin
         if (check_span) check("done_cycle", 32'(cyc + 1 - t), 32'd203);
         check("busy_at_done", 32'(busy), 32'h0);
         check("all_bytes_seen", 32'(sb_q.size()), 32'h0);
         @(negedge clock);
         check("done_one_pulse", 32'({busy, done}), 32'h0);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic check_cleared(input string name);
      @(negedge clock);
      check(name, 32'({busy, rk_valid, key_ready, done, rk_last, rk_round, rk_out}), 32'h0);
   endtask

   initial begin
      int t;
      int base;
      int n;

      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      check_cleared("reset_outputs");
      @(posedge clock);
      #1;

      push_run(0, 176);
      start_pulse(t);
      drive_key(A1_RK[0], 0, 16);
      wait_done(t, 1'b1);

      base = last_cnt;
      push_run(1, 176);
      start_pulse(t);
      drive_key(KEY2, 0, 16);
      wait_done(t, 1'b1);
      check("rk_last_count", 32'(last_cnt - base), 32'd11);

      push_run(2, 176);
      start_pulse(t);
      drive_key(128'h0, 0, 16);
      wait_done(t, 1'b1);

      rk_gap = 40;
      push_run(2, 176);
      start_pulse(t);
      drive_key(128'h0, 30, 16);
      wait_done(t, 1'b0);
      rk_gap = 0;
      @(posedge clock);
      #1;

      push_run(0, 176);
      start_pulse(t);
      drive_key(A1_RK[0], 0, 16);
      n = 0;
      while (n < 300 && !(rk_valid && rk_round == 4'd3)) begin
         @(posedge clock);
         #1;
         n++;
      end
      check("reached_round3", 32'(rk_round), 32'd3);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      wait_done(t, 1'b1);

      start_pulse(t);
      drive_key(A1_RK[0], 0, 7);
      key_valid = 1'b1;
      key_in    = A1_RK[0][63:56];
      reset     = 1'b1;
      @(posedge clock);
      #1;
      reset     = 1'b0;
      key_valid = 1'b0;
      check_cleared("reset_in_load");
      @(posedge clock);
      #1;

      base = obs;
      push_run(0, 90);
      start_pulse(t);
      drive_key(A1_RK[0], 0, 16);
      n = 0;
      while (n < 400 && (obs - base) != 89) begin
         @(posedge clock);
         #1;
         n++;
      end
      check("reached_round5_byte9", 32'(obs - base), 32'd89);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check_cleared("reset_in_emit");
      check("scoreboard_flushed", 32'(sb_q.size()), 32'h0);
      @(posedge clock);
      #1;

      push_run(0, 176);
      start_pulse(t);
      drive_key(A1_RK[0], 0, 16);
      wait_done(t, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Byte-serial AES-128 key-schedule stage sitting directly upstream of the byte-serial encryption datapath. It accepts the 128-bit cipher key one byte per handshake and expands it per FIPS-197. It streams round keys 0 through 10 one byte per cycle, each tagged with its round index, so the encryption stage can XOR them into its state bytes during AddRoundKey.

## Interface
- No parameters. Rcon sequence is fixed: 01,02,04,08,10,20,40,80,1B,36.
- Clocking and reset: one clock; reset is synchronous and active-high.
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all state and outputs.
- start  in  1  in IDLE, begins a key load; ignored in every other state.
- key_in  in  8  cipher key byte; byte 0 is key[127:120].
- key_valid  in  1  key_in valid this cycle.
- key_ready  out  1  high only in LOAD; a byte is taken when key_valid & key_ready.
- rk_out  out  8  current round-key byte; 0 when rk_valid is low.
- rk_valid  out  1  high only in EMIT.
- rk_ready  in  1  consumer accepts rk_out when rk_valid & rk_ready.
- rk_round  out  4  round index 0..10 of the byte on rk_out; 0 when idle.
- rk_last  out  1  rk_valid high and byte index 15 of the current round.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after round 10 byte 15 is accepted.

## Operation
- State: 128-bit round-key register K, 4-bit byte counter cnt, and 4-bit round counter rnd.
- IDLE:
  - All outputs are 0.
  - start -> LOAD, with cnt=0 and rnd=0.
- LOAD:
  - On each key_valid cycle: K <= {K[119:0], key_in} and cnt++.
  - On the 16th accepted byte (cnt==15): -> EMIT with cnt=0.
  - Gaps in key_valid stall the load with no state change.
- EMIT:
  - rk_out = K[127-8*cnt -: 8], i.e. FIPS-197 byte order, byte 0 first.
  - On each accept, cnt++ (4-bit, wraps 15->0).
  - rk_ready low holds rk_out, rk_round and cnt stable.
  - Accept at cnt==15 with rnd==10: -> IDLE and pulse done.
  - Accept at cnt==15 with rnd<10: -> EXPAND.
- EXPAND (exactly one cycle):
  - Words w0..w3 = K[127:96], K[95:64], K[63:32], K[31:0].
  - t = SubWord(RotWord(w3)) ^ {Rcon[rnd+1],24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - K <= {w0',w1',w2',w3'}; rnd++; -> EMIT with cnt=0.
  - Uses four combinational S-box lookups in this cycle.
- reset in any state: -> IDLE; K, cnt, rnd and all outputs are 0 the next cycle. Any partial load or emission is discarded.
- start asserted with reset: reset wins.
- start asserted while busy: no effect.
- After done, a new start begins a fresh load. No key is retained for reuse.

## Timing
- All outputs are registered or decoded from registered state only. There are no input-to-output combinational paths except that rk_valid/rk_out do not depend on rk_ready.
- start sampled at edge T -> key_ready high from cycle T+1.
- Continuous key_valid -> bytes taken at T+1..T+16; rk_valid high from T+17.
- Continuous rk_ready:
  - Each round emits 16 consecutive bytes, then one EXPAND cycle with rk_valid=0.
  - Full schedule spans 11*16+10 = 186 cycles.
  - done is high on the first IDLE cycle, T+203.
- busy rises at T+1 and falls together with done rising.
- rk_last coincides with rk_valid on byte 15 of every round, including round 0 and round 10.

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, continuous handshakes:
  - round 0 stream = key;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - done at T+203.
- Key 000102030405060708090a0b0c0d0e0f:
  - round 10 = 13111d7fe3944a17f307a78b4d2b30c5;
  - rk_round steps 0..10;
  - rk_last asserts 11 times.
- All-zero key:
  - round 1 = 62636363626363636263636362636363;
  - random rk_ready and key_valid gaps -> identical byte streams, with rk_out stable while stalled.
- start pulsed during EMIT round 3 -> ignored; stream and done timing unchanged.
- reset asserted at LOAD byte 7 and again at EMIT round 5 byte 9:
  - next cycle: busy=0, rk_valid=0, key_ready=0;
  - a subsequent full A.1 run still produces the correct keys.
